// File: rtl/patdet_pkg.sv
// Shared types and constants for the serial pattern detector.
// match_cnt logic is built only when PATDET_CNT_EN is defined.
package patdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_t;

  localparam logic DEF_OVERLAP = 1'b1;
  localparam logic DEF_STRICT  = 1'b0;

  // Low len bits set; len >= 32 gives all ones.
  function automatic logic [31:0] lenmask(input int unsigned len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/patdet_cmp.sv
// Combinational masked comparison of the newest len history bits against the pattern.
module patdet_cmp
  import patdet_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic [MAX_LEN-1:0]             hist,
  input  logic [MAX_LEN-1:0]             pattern,
  input  logic [MAX_LEN-1:0]             mask,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  output logic                           hit
);

  logic [MAX_LEN-1:0] diff;
  logic [31:0]        lm;

  assign diff = (hist ^ pattern) & mask;
  assign lm   = lenmask(32'(len));
  assign hit  = ((32'(diff)) & lm) == '0;

endmodule

// File: rtl/pattern_detect_prm.sv
// Serial pattern detector: IDLE/FILL/RUN FSM, history shift register, optional
// saturating match counter (built when PATDET_CNT_EN is defined).
module pattern_detect_prm
  import patdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [MAX_LEN-1:0]             cfg_mask,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cfg_strict,
  input  logic                           enable,
  input  logic                           valid,
  input  logic                           in,
  input  logic                           cnt_clr,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           busy
);

  localparam int LW = $clog2(MAX_LEN+1);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] hist, hist_n, hist_sh;
  logic [LW-1:0]      fill, fill_n, fill_inc;
  logic               match_n;
  logic [MAX_LEN-1:0] pat_q, mask_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q, strict_q;
  logic               hit;

  function automatic logic len_ok(input logic [LW-1:0] l);
    return (int'(l) >= 2) && (int'(l) <= MAX_LEN);
  endfunction

  assign hist_sh  = {hist[MAX_LEN-2:0], in};
  assign fill_inc = fill + LW'(1);

  patdet_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
    .hist    (hist_sh),
    .pattern (pat_q),
    .mask    (mask_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      mask_q   <= '1;
      len_q    <= LW'(MAX_LEN);
      ovl_q    <= DEF_OVERLAP;
      strict_q <= DEF_STRICT;
    end else if (cfg_we) begin
      pat_q    <= cfg_pattern;
      mask_q   <= cfg_mask;
      len_q    <= cfg_len;
      ovl_q    <= cfg_overlap;
      strict_q <= cfg_strict;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      match <= match_n;
    end
  end

  // The completing bit is compared on the shifted history in the same cycle,
  // so FILL->RUN and the first match coincide.
  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    match_n = 1'b0;
    if (cfg_we) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = (enable && len_ok(cfg_len)) ? ST_FILL : ST_IDLE;
    end else if (!enable) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (len_ok(len_q)) state_n = ST_FILL;
        end
        ST_FILL, ST_RUN: begin
          if (valid) begin
            hist_n = hist_sh;
            if (state == ST_FILL) fill_n = fill_inc;
            if (state == ST_RUN || fill_inc == len_q) begin
              state_n = ST_RUN;
              if (hit) begin
                match_n = 1'b1;
                if (!ovl_q) begin
                  hist_n  = '0;
                  fill_n  = '0;
                  state_n = ST_FILL;
                end
              end
            end
          end else if (strict_q) begin
            hist_n  = '0;
            fill_n  = '0;
            state_n = ST_FILL;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef PATDET_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) match_cnt <= '0;
    else if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detect_prm.sv
// Directed self-checking bench for pattern_detect_prm (CNT_W=2 to reach saturation).
module tb_pattern_detect_prm;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN+1);
`ifdef PATDET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, cfg_we, cfg_overlap, cfg_strict, enable, valid, in, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern, cfg_mask;
  logic [LW-1:0]      cfg_len;
  logic               match, busy;
  logic [CNT_W-1:0]   match_cnt;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  pattern_detect_prm #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_strict(cfg_strict), .enable(enable), .valid(valid), .in(in),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int v);
    return CNT_ON ? 32'(v) : 32'd0;
  endfunction

  task automatic cfg(input int len, input logic [7:0] pat, input logic [7:0] msk,
                     input logic ovl, input logic str, input logic clr);
    cfg_we = 1'b1; cfg_len = LW'(len); cfg_pattern = pat; cfg_mask = msk;
    cfg_overlap = ovl; cfg_strict = str; enable = 1'b1; valid = 1'b0; cnt_clr = clr;
    cyc();
    cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  // Feeds n bits, MSB-first from bits; exp holds the expected match after each bit.
  task automatic run_bits(input string tag, input logic [15:0] bits, input logic [15:0] exp,
                          input int n);
    logic [15:0] b, e;
    b = bits; e = exp;
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; in = b[n-1-i];
      cyc();
      chk($sformatf("%s_bit%0d", tag, i+1), {31'd0, match}, {31'd0, e[n-1-i]});
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_strict = 1'b0; enable = 1'b0; valid = 1'b0; in = 1'b0;
    cnt_clr = 1'b0;
    cyc(); cyc();
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_no_enable", {31'd0, busy}, 32'd0);

    // len 5, 10110, overlapping
    cfg(5, 8'b10110, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("cfg_busy", {31'd0, busy}, 32'd1);
    run_bits("ovl", 16'b10110110, 16'b00001001, 8);
    cyc();
    chk("ovl_cnt", 32'(match_cnt), ecnt(2));

    // same, non-overlapping
    cfg(5, 8'b10110, 8'hFF, 1'b0, 1'b0, 1'b1);
    run_bits("novl", 16'b10110110, 16'b00001000, 8);
    cyc();
    chk("novl_cnt", 32'(match_cnt), ecnt(1));

    // don't-care bit
    cfg(4, 8'b1001, 8'b1011, 1'b1, 1'b0, 1'b0);
    run_bits("mask", 16'b1101, 16'b0001, 4);

    // valid gap, strict off then on
    cfg(3, 8'b111, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_bits("gap_ns", 16'b11, 16'b00, 2);
    cyc();
    chk("gap_ns_hold", {31'd0, match}, 32'd0);
    run_bits("gap_ns_last", 16'b1, 16'b1, 1);
    cfg(3, 8'b111, 8'hFF, 1'b1, 1'b1, 1'b0);
    run_bits("gap_s", 16'b11, 16'b00, 2);
    cyc();
    chk("gap_s_busy", {31'd0, busy}, 32'd1);
    run_bits("gap_s_last", 16'b1, 16'b0, 1);

    // saturation and clear priority
    cfg(2, 8'b11, 8'hFF, 1'b1, 1'b0, 1'b1);
    run_bits("sat", 16'b111111, 16'b011111, 6);
    cyc();
    chk("sat_cnt", 32'(match_cnt), ecnt(3));
    run_bits("clr_pre", 16'b1, 16'b1, 1);
    valid = 1'b1; in = 1'b1; cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0; valid = 1'b0;
    chk("clr_win_cnt", 32'(match_cnt), 32'd0);
    chk("clr_win_match", {31'd0, match}, 32'd1);
    cyc();
    chk("clr_after_cnt", 32'(match_cnt), ecnt(1));

    // enable drop
    enable = 1'b0;
    cyc();
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_match", {31'd0, match}, 32'd0);
    enable = 1'b1;
    cyc();
    chk("reen_busy", {31'd0, busy}, 32'd1);

    // rst on completing bit, then defaults (len 8, pattern 0)
    cfg(3, 8'b111, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_bits("rst_pre", 16'b11, 16'b00, 2);
    rst = 1'b1; valid = 1'b1; in = 1'b1;
    cyc();
    rst = 1'b0; valid = 1'b0;
    chk("rstmid_match", {31'd0, match}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("rst_def_busy", {31'd0, busy}, 32'd1);
    run_bits("def", 16'b00000000, 16'b00000001, 8);

    // cfg_we on completing bit
    cfg(3, 8'b111, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_bits("we_pre", 16'b11, 16'b00, 2);
    cfg_we = 1'b1; valid = 1'b1; in = 1'b1;
    cyc();
    cfg_we = 1'b0; valid = 1'b0;
    chk("we_match", {31'd0, match}, 32'd0);
    chk("we_busy", {31'd0, busy}, 32'd1);
    run_bits("we_post", 16'b111, 16'b001, 3);

    // invalid lengths
    cfg(1, 8'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("len1_busy", {31'd0, busy}, 32'd0);
    cfg(0, 8'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    cfg(9, 8'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("len9_busy", {31'd0, busy}, 32'd0);
    cfg(2, 8'b01, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("len2_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
